// File: rtl/fp_normalizer.sv
// Post-add normalization for the FP add/sub datapath: resolves a sum carry with one
// right shift, or cancellation with one left shift per cycle, under valid/ready handshakes.
module fp_normalizer #(
    parameter int ExponentSize   = 8,
    parameter int MantissaSize   = 23,
    parameter int ShiftCountSize = 5
) (
    input  logic                      i_Clk,
    input  logic                      i_Reset_n,
    input  logic                      i_InValid,
    output logic                      o_InReady,
    input  logic [MantissaSize+1:0]   i_SumMantissa,
    input  logic [ExponentSize-1:0]   i_InExponent,
    input  logic                      i_InSign,
    output logic                      o_OutValid,
    input  logic                      i_OutReady,
    output logic [MantissaSize-1:0]   o_Mantissa,
    output logic [ExponentSize-1:0]   o_Exponent,
    output logic                      o_Sign,
    output logic                      o_RoundBit,
    output logic [ShiftCountSize-1:0] o_ShiftCount,
    output logic                      o_ZeroFlag,
    output logic                      o_Overflow,
    output logic                      o_Underflow
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                    r_state;
    logic [MantissaSize+1:0]   r_m;
    logic [ExponentSize-1:0]   r_e;
    logic                      r_sign;
    logic                      r_round;
    logic [ShiftCountSize-1:0] r_shift;
    logic                      r_zero;
    logic                      r_ovf;
    logic                      r_unf;

    state_t                    w_nextState;
    logic [MantissaSize+1:0]   w_m;
    logic [ExponentSize-1:0]   w_e;
    logic                      w_sign;
    logic                      w_round;
    logic [ShiftCountSize-1:0] w_shift;
    logic                      w_zero;
    logic                      w_ovf;
    logic                      w_unf;

    logic [ExponentSize-1:0]   w_expInc;
    logic [ExponentSize-1:0]   w_expDec;

    assign w_expInc = i_InExponent + ExponentSize'(1);
    assign w_expDec = r_e - ExponentSize'(1);

    always_comb begin
        w_nextState = r_state;
        w_m         = r_m;
        w_e         = r_e;
        w_sign      = r_sign;
        w_round     = r_round;
        w_shift     = r_shift;
        w_zero      = r_zero;
        w_ovf       = r_ovf;
        w_unf       = r_unf;
        case (r_state)
            IDLE: begin
                if (i_InValid) begin
                    w_sign      = i_InSign;
                    w_m         = i_SumMantissa;
                    w_e         = i_InExponent;
                    w_round     = 1'b0;
                    w_shift     = '0;
                    w_zero      = 1'b0;
                    w_ovf       = 1'b0;
                    w_unf       = 1'b0;
                    w_nextState = DONE;
                    if (i_SumMantissa == '0) begin
                        w_zero = 1'b1;
                        w_e    = '0;
                    end else if (i_SumMantissa[MantissaSize+1]) begin
                        w_m     = i_SumMantissa >> 1;
                        w_e     = w_expInc;
                        w_round = i_SumMantissa[0];
                        // Saturated exponent means infinity, which carries no fraction.
                        if (w_expInc == '1) begin
                            w_ovf                   = 1'b1;
                            w_m[MantissaSize-1:0]   = '0;
                        end
                    end else if (i_SumMantissa[MantissaSize]) begin
                        w_nextState = DONE;
                    end else if (i_InExponent <= ExponentSize'(1)) begin
                        w_unf = 1'b1;
                        w_e   = '0;
                    end else begin
                        w_nextState = SHIFT;
                    end
                end
            end
            SHIFT: begin
                w_m     = r_m << 1;
                w_e     = w_expDec;
                w_shift = r_shift + ShiftCountSize'(1);
                // Old M[MantissaSize-1] becomes the hidden bit after this shift.
                if (r_m[MantissaSize-1]) begin
                    w_nextState = DONE;
                end else if (w_expDec == ExponentSize'(1)) begin
                    w_nextState = DONE;
                    w_unf       = 1'b1;
                    w_e         = '0;
                end
            end
            DONE: begin
                if (i_OutReady) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state <= IDLE;
            r_m     <= '0;
            r_e     <= '0;
            r_sign  <= 1'b0;
            r_round <= 1'b0;
            r_shift <= '0;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_m     <= w_m;
            r_e     <= w_e;
            r_sign  <= w_sign;
            r_round <= w_round;
            r_shift <= w_shift;
            r_zero  <= w_zero;
            r_ovf   <= w_ovf;
            r_unf   <= w_unf;
        end
    end

    assign o_InReady    = (r_state == IDLE);
    assign o_OutValid   = (r_state == DONE);
    assign o_Mantissa   = r_m[MantissaSize-1:0];
    assign o_Exponent   = r_e;
    assign o_Sign       = r_sign;
    assign o_RoundBit   = r_round;
    assign o_ShiftCount = r_shift;
    assign o_ZeroFlag   = r_zero;
    assign o_Overflow   = r_ovf;
    assign o_Underflow  = r_unf;

endmodule

// File: tb/tb_fp_normalizer.sv
// Directed bench for fp_normalizer: hand-computed vectors for carry, cancellation,
// underflow, overflow, zero, backpressure and asynchronous reset.
module tb_fp_normalizer;

    logic        clk = 1'b0;
    logic        resetN;
    logic        inValid;
    logic        inReady;
    logic [24:0] sumMantissa;
    logic [7:0]  inExponent;
    logic        inSign;
    logic        outValid;
    logic        outReady;
    logic [22:0] mantissa;
    logic [7:0]  exponent;
    logic        sign;
    logic        roundBit;
    logic [4:0]  shiftCount;
    logic        zeroFlag;
    logic        overflow;
    logic        underflow;

    int numChecks = 0;
    int numFails  = 0;
    int latency;
    logic readyStayedLow;

    fp_normalizer #(.ExponentSize(8), .MantissaSize(23), .ShiftCountSize(5)) dut (
        .i_Clk(clk),
        .i_Reset_n(resetN),
        .i_InValid(inValid),
        .o_InReady(inReady),
        .i_SumMantissa(sumMantissa),
        .i_InExponent(inExponent),
        .i_InSign(inSign),
        .o_OutValid(outValid),
        .i_OutReady(outReady),
        .o_Mantissa(mantissa),
        .o_Exponent(exponent),
        .o_Sign(sign),
        .o_RoundBit(roundBit),
        .o_ShiftCount(shiftCount),
        .o_ZeroFlag(zeroFlag),
        .o_Overflow(overflow),
        .o_Underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        numChecks++;
        assert (observed === expected) else begin
            numFails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presents one operation and returns #1 after the edge that accepts it.
    task automatic applyStimulus(input logic [24:0] sum, input logic [7:0] expIn, input logic signIn);
        @(negedge clk);
        sumMantissa = sum;
        inExponent  = expIn;
        inSign      = signIn;
        inValid     = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic waitResult(output int lat, output logic stayedLow);
        lat       = 1;
        stayedLow = 1'b1;
        while (outValid !== 1'b1 && lat < 100) begin
            if (inReady !== 1'b0) stayedLow = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic releaseResult();
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        checkOutput("release_inready", 32'(inReady), 32'h1);
        checkOutput("release_outvalid", 32'(outValid), 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        resetN      = 1'b0;
        inValid     = 1'b0;
        sumMantissa = '0;
        inExponent  = '0;
        inSign      = 1'b0;
        outReady    = 1'b0;
        #12;
        checkOutput("reset_inready", 32'(inReady), 32'h1);
        checkOutput("reset_outvalid", 32'(outValid), 32'h0);
        checkOutput("reset_exponent", 32'(exponent), 32'h0);
        checkOutput("reset_flags", 32'({zeroFlag, overflow, underflow, roundBit}), 32'h0);
        @(negedge clk);
        resetN = 1'b1;

        $display("[TB] carry case");
        applyStimulus(25'h1800000, 8'h80, 1'b0);
        waitResult(latency, readyStayedLow);
        checkOutput("carry_latency", 32'(latency), 32'd1);
        checkOutput("carry_exponent", 32'(exponent), 32'h81);
        checkOutput("carry_mantissa", 32'(mantissa), 32'h400000);
        checkOutput("carry_round", 32'(roundBit), 32'h0);
        checkOutput("carry_shift", 32'(shiftCount), 32'h0);

        $display("[TB] backpressure with ignored input");
        sumMantissa = 25'h0;
        inExponent  = 8'h55;
        inValid     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_outvalid", 32'(outValid), 32'h1);
            checkOutput("hold_inready", 32'(inReady), 32'h0);
            checkOutput("hold_result", 32'({exponent, mantissa}), 32'({8'h81, 23'h400000}));
        end
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        checkOutput("handoff_inready", 32'(inReady), 32'h1);
        checkOutput("handoff_outvalid", 32'(outValid), 32'h0);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        checkOutput("zero_outvalid", 32'(outValid), 32'h1);
        checkOutput("zero_flag", 32'(zeroFlag), 32'h1);
        checkOutput("zero_exponent", 32'(exponent), 32'h0);
        checkOutput("zero_mantissa", 32'(mantissa), 32'h0);
        releaseResult();

        $display("[TB] already normalized");
        applyStimulus(25'h0800000, 8'h7F, 1'b1);
        waitResult(latency, readyStayedLow);
        checkOutput("norm_latency", 32'(latency), 32'd1);
        checkOutput("norm_mantissa", 32'(mantissa), 32'h0);
        checkOutput("norm_exponent", 32'(exponent), 32'h7F);
        checkOutput("norm_sign", 32'(sign), 32'h1);
        checkOutput("norm_zero_cleared", 32'(zeroFlag), 32'h0);
        releaseResult();

        $display("[TB] carry with round bit");
        applyStimulus(25'h1800001, 8'h10, 1'b0);
        waitResult(latency, readyStayedLow);
        checkOutput("round_exponent", 32'(exponent), 32'h11);
        checkOutput("round_mantissa", 32'(mantissa), 32'h400000);
        checkOutput("round_bit", 32'(roundBit), 32'h1);
        checkOutput("round_sign", 32'(sign), 32'h0);
        releaseResult();

        $display("[TB] single left shift");
        applyStimulus(25'h0400003, 8'h80, 1'b0);
        waitResult(latency, readyStayedLow);
        checkOutput("shift1_latency", 32'(latency), 32'd2);
        checkOutput("shift1_count", 32'(shiftCount), 32'd1);
        checkOutput("shift1_exponent", 32'(exponent), 32'h7F);
        checkOutput("shift1_mantissa", 32'(mantissa), 32'h000006);
        checkOutput("shift1_round", 32'(roundBit), 32'h0);
        releaseResult();

        $display("[TB] maximum cancellation");
        applyStimulus(25'h0000001, 8'h7F, 1'b0);
        waitResult(latency, readyStayedLow);
        checkOutput("maxc_latency", 32'(latency), 32'd24);
        checkOutput("maxc_inready_low", 32'(readyStayedLow), 32'h1);
        checkOutput("maxc_count", 32'(shiftCount), 32'd23);
        checkOutput("maxc_exponent", 32'(exponent), 32'h68);
        checkOutput("maxc_mantissa", 32'(mantissa), 32'h0);
        checkOutput("maxc_underflow", 32'(underflow), 32'h0);
        releaseResult();

        $display("[TB] underflow during shift");
        applyStimulus(25'h0000001, 8'h03, 1'b0);
        waitResult(latency, readyStayedLow);
        checkOutput("unf_latency", 32'(latency), 32'd3);
        checkOutput("unf_flag", 32'(underflow), 32'h1);
        checkOutput("unf_exponent", 32'(exponent), 32'h0);
        checkOutput("unf_mantissa", 32'(mantissa), 32'h000004);
        checkOutput("unf_count", 32'(shiftCount), 32'd2);
        releaseResult();

        $display("[TB] underflow at acceptance");
        applyStimulus(25'h0000100, 8'h01, 1'b0);
        waitResult(latency, readyStayedLow);
        checkOutput("unf0_latency", 32'(latency), 32'd1);
        checkOutput("unf0_flag", 32'(underflow), 32'h1);
        checkOutput("unf0_exponent", 32'(exponent), 32'h0);
        checkOutput("unf0_mantissa", 32'(mantissa), 32'h000100);
        releaseResult();

        $display("[TB] overflow");
        applyStimulus(25'h1000000, 8'hFE, 1'b0);
        waitResult(latency, readyStayedLow);
        checkOutput("ovf_flag", 32'(overflow), 32'h1);
        checkOutput("ovf_exponent", 32'(exponent), 32'hFF);
        checkOutput("ovf_mantissa", 32'(mantissa), 32'h0);
        checkOutput("ovf_underflow_cleared", 32'(underflow), 32'h0);
        releaseResult();

        applyStimulus(25'h1FFFFFE, 8'hFE, 1'b1);
        waitResult(latency, readyStayedLow);
        checkOutput("ovf2_flag", 32'(overflow), 32'h1);
        checkOutput("ovf2_mantissa_forced", 32'(mantissa), 32'h0);
        checkOutput("ovf2_exponent", 32'(exponent), 32'hFF);
        releaseResult();

        $display("[TB] reset in the middle of shifting");
        applyStimulus(25'h0000001, 8'h7F, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        checkOutput("pre_reset_inready", 32'(inReady), 32'h0);
        resetN = 1'b0;
        #1;
        checkOutput("midreset_outvalid", 32'(outValid), 32'h0);
        checkOutput("midreset_inready", 32'(inReady), 32'h1);
        checkOutput("midreset_count", 32'(shiftCount), 32'h0);
        checkOutput("midreset_exponent", 32'(exponent), 32'h0);
        @(negedge clk);
        resetN = 1'b1;

        applyStimulus(25'h0800000, 8'h20, 1'b0);
        waitResult(latency, readyStayedLow);
        checkOutput("recover_latency", 32'(latency), 32'd1);
        checkOutput("recover_exponent", 32'(exponent), 32'h20);
        releaseResult();

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
